// File: rtl/scrypt_pkg.sv
// Shared constants and state type for the header receive path.
// No logic of its own; imported by the receive controller and its helpers.
package scrypt_pkg;

  localparam int HEADER_BYTES = 80;
  localparam int ADDR_W       = 7;

  typedef enum logic [1:0] {
    RECV  = 2'd0,
    WRITE = 2'd1,
    FULL  = 2'd2
  } rx_state_t;

  function automatic logic is_last_byte(input logic [ADDR_W-1:0] idx);
    return idx == ADDR_W'(HEADER_BYTES - 1);
  endfunction

endpackage

// File: rtl/timeout_counter.sv
// Idle-cycle counter: expired is high combinationally on the TIMEOUT_CYCLES-th enabled cycle.
// Latency: expires on the same cycle the limit is reached; no backpressure, clear dominates enable.
module timeout_counter #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count;

  assign expired = enable && !clear && (count == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      // Restart after firing so a stuck enable cannot wrap the counter.
      count <= expired ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/header_rx_ctrl.sv
// Collects 80 received bytes into the header register, one load strobe per byte.
// Latency: load one cycle after rx_valid; bytes arriving while busy or full are dropped and flag overrun.
module header_rx_ctrl
  import scrypt_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              rx_error,
  input  logic              header_ack,
  output logic [7:0]        rx_out,
  output logic [ADDR_W-1:0] address,
  output logic              load,
  output logic              header_valid,
  output logic              overrun
);

  rx_state_t         state;
  logic [ADDR_W-1:0] cnt;
  logic              idle_clear;
  logic              idle_enable;
  logic              idle_expired;

  assign address = cnt;

  // Idle time only matters while a partial header is waiting for its next byte.
  assign idle_clear  = (state != RECV) || (cnt == '0) || rx_valid;
  assign idle_enable = (state == RECV) && (cnt != '0) && !rx_valid;

  timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_idle (
    .clk     (clk),
    .n_rst   (n_rst),
    .clear   (idle_clear),
    .enable  (idle_enable),
    .expired (idle_expired)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= RECV;
      cnt          <= '0;
      rx_out       <= 8'h00;
      load         <= 1'b0;
      header_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      load <= 1'b0;
      case (state)
        RECV: begin
          if (rx_error) begin
            cnt <= '0;
          end else if (rx_valid) begin
            rx_out <= rx_data;
            load   <= 1'b1;
            state  <= WRITE;
          end else if (idle_expired) begin
            cnt <= '0;
          end
        end
        WRITE: begin
          // The load for this cycle is already on the wire; an error only rewinds cnt.
          if (rx_error) begin
            cnt   <= '0;
            state <= RECV;
          end else begin
            if (rx_valid) overrun <= 1'b1;
            if (is_last_byte(cnt)) begin
              header_valid <= 1'b1;
              state        <= FULL;
            end else begin
              cnt   <= cnt + ADDR_W'(1);
              state <= RECV;
            end
          end
        end
        FULL: begin
          if (header_ack) begin
            cnt          <= '0;
            overrun      <= 1'b0;
            header_valid <= 1'b0;
            state        <= RECV;
          end
          if (rx_valid) overrun <= 1'b1;
        end
        default: state <= RECV;
      endcase
    end
  end

endmodule

// File: tb/tb_header_rx_ctrl.sv
// Directed bench for header_rx_ctrl: default-timeout instance plus a TIMEOUT_CYCLES=16 instance on shared inputs.
module tb_header_rx_ctrl;

  logic       clk;
  logic       n_rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_error;
  logic       header_ack;

  logic [7:0] rx_out,   t_rx_out;
  logic [6:0] address,  t_address;
  logic       load,     t_load;
  logic       header_valid, t_header_valid;
  logic       overrun,  t_overrun;

  int passes = 0;
  int total  = 0;

  header_rx_ctrl dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_error     (rx_error),
    .header_ack   (header_ack),
    .rx_out       (rx_out),
    .address      (address),
    .load         (load),
    .header_valid (header_valid),
    .overrun      (overrun)
  );

  header_rx_ctrl #(.TIMEOUT_CYCLES(16)) dut_t (
    .clk          (clk),
    .n_rst        (n_rst),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_error     (rx_error),
    .header_ack   (header_ack),
    .rx_out       (t_rx_out),
    .address      (t_address),
    .load         (t_load),
    .header_valid (t_header_valid),
    .overrun      (t_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  // One-cycle rx_valid strobe; returns at the falling edge inside the following cycle.
  task automatic strobe(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  initial begin
    n_rst      = 1'b0;
    rx_data    = 8'h00;
    rx_valid   = 1'b0;
    rx_error   = 1'b0;
    header_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rx_out", 32'(rx_out), 32'h0);
    check("rst_address", 32'(address), 32'h0);
    check("rst_load", 32'(load), 32'h0);
    check("rst_header_valid", 32'(header_valid), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    check("rst_t_address", 32'(t_address), 32'h0);
    n_rst = 1'b1;

    // Full header: bytes 0x00..0x4F, strobes 20 cycles apart.
    for (int i = 0; i < 80; i++) begin
      strobe(8'(i));
      check("fill_load", 32'(load), 32'd1);
      check("fill_address", 32'(address), 32'(i));
      check("fill_data", 32'(rx_out), 32'(i));
      if (i < 79) begin
        @(negedge clk);
        check("fill_load_idle", 32'(load), 32'd0);
        check("fill_hv_early", 32'(header_valid), 32'd0);
        repeat (17) @(negedge clk);
      end
    end
    @(negedge clk);
    check("full_hv", 32'(header_valid), 32'd1);
    check("full_load", 32'(load), 32'd0);
    check("full_address", 32'(address), 32'd79);
    check("full_rx_out", 32'(rx_out), 32'h4F);

    // Byte while full is dropped, then ack releases the header.
    strobe(8'hAA);
    check("full_drop_load", 32'(load), 32'd0);
    check("full_drop_overrun", 32'(overrun), 32'd1);
    check("full_drop_hv", 32'(header_valid), 32'd1);
    check("full_drop_rx_out", 32'(rx_out), 32'h4F);
    check("full_drop_address", 32'(address), 32'd79);
    @(negedge clk);
    header_ack = 1'b1;
    @(negedge clk);
    header_ack = 1'b0;
    check("ack_hv", 32'(header_valid), 32'd0);
    check("ack_overrun", 32'(overrun), 32'd0);
    check("ack_address", 32'(address), 32'd0);
    strobe(8'h11);
    check("ack_next_load", 32'(load), 32'd1);
    check("ack_next_address", 32'(address), 32'd0);
    check("ack_next_data", 32'(rx_out), 32'h11);

    // Ten bytes then rx_error rewinds to address 0.
    for (int i = 1; i < 10; i++) begin
      strobe(8'h30 + 8'(i));
      check("err_fill_address", 32'(address), 32'(i));
    end
    @(negedge clk);
    rx_error = 1'b1;
    @(negedge clk);
    rx_error = 1'b0;
    check("err_address", 32'(address), 32'd0);
    strobe(8'h5A);
    check("err_next_load", 32'(load), 32'd1);
    check("err_next_address", 32'(address), 32'd0);
    check("err_next_data", 32'(rx_out), 32'h5A);

    // Back-to-back strobes: first loads, second dropped.
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = 8'h21;
    @(negedge clk);
    rx_data  = 8'h22;
    check("b2b_load", 32'(load), 32'd1);
    check("b2b_address", 32'(address), 32'd1);
    check("b2b_data", 32'(rx_out), 32'h21);
    @(negedge clk);
    rx_valid = 1'b0;
    check("b2b_drop_load", 32'(load), 32'd0);
    check("b2b_overrun", 32'(overrun), 32'd1);
    check("b2b_drop_data", 32'(rx_out), 32'h21);
    check("b2b_address_next", 32'(address), 32'd2);

    // Asynchronous reset in the middle of a header.
    @(negedge clk);
    n_rst = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    check("rst2_overrun", 32'(overrun), 32'd0);
    check("rst2_address", 32'(address), 32'd0);
    for (int i = 0; i < 39; i++) strobe(8'(i));
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = 8'h27;
    @(negedge clk);
    rx_data  = 8'hEE;
    @(negedge clk);
    rx_valid = 1'b0;
    check("pre_rst_address", 32'(address), 32'd40);
    check("pre_rst_overrun", 32'(overrun), 32'd1);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = 8'h77;
    @(posedge clk);
    #1;
    check("pre_rst_load", 32'(load), 32'd1);
    #1;
    n_rst = 1'b0;
    #1;
    check("async_load", 32'(load), 32'd0);
    check("async_rx_out", 32'(rx_out), 32'h0);
    check("async_address", 32'(address), 32'd0);
    check("async_hv", 32'(header_valid), 32'd0);
    check("async_overrun", 32'(overrun), 32'd0);
    rx_valid = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    strobe(8'h66);
    check("post_rst_load", 32'(load), 32'd1);
    check("post_rst_address", 32'(address), 32'd0);
    check("post_rst_data", 32'(rx_out), 32'h66);

    // Idle timeout on the 16-cycle instance: 16 idle cycles discard progress.
    @(negedge clk);
    n_rst = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 5; i++) strobe(8'hB0 + 8'(i));
    check("to16_last_address", 32'(t_address), 32'd4);
    repeat (17) @(negedge clk);
    check("to16_address_idle", 32'(t_address), 32'd0);
    rx_valid = 1'b1;
    rx_data  = 8'hC1;
    @(negedge clk);
    rx_valid = 1'b0;
    check("to16_load", 32'(t_load), 32'd1);
    check("to16_address", 32'(t_address), 32'd0);
    check("to16_data", 32'(t_rx_out), 32'hC1);

    // Fifteen idle cycles keep the partial header.
    @(negedge clk);
    n_rst = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 5; i++) strobe(8'hD0 + 8'(i));
    repeat (16) @(negedge clk);
    check("to15_address_idle", 32'(t_address), 32'd5);
    rx_valid = 1'b1;
    rx_data  = 8'hC2;
    @(negedge clk);
    rx_valid = 1'b0;
    check("to15_load", 32'(t_load), 32'd1);
    check("to15_address", 32'(t_address), 32'd5);
    check("to15_data", 32'(t_rx_out), 32'hC2);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
